// File: rtl/axis_frame_pkg.sv
// rtl/axis_frame_pkg.sv - shared state encoding and low-aligned tkeep helper
package axis_frame_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned MAX_KEEP_WIDTH = 64;

  // Remainder 0 means a fully populated beat, so all keep_width lanes are set.
  function automatic logic [MAX_KEEP_WIDTH-1:0] keep_mask(input int unsigned r,
                                                          input int unsigned keep_width);
    logic [MAX_KEEP_WIDTH-1:0] m;
    int unsigned n;
    n = (r == 0) ? keep_width : r;
    m = '0;
    for (int unsigned i = 0; i < MAX_KEEP_WIDTH; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_frame_gen_pattern.sv
// rtl/axis_frame_gen_pattern.sv - incrementing byte-lane pattern from a base offset
module axis_frame_gen_pattern #(
  parameter int KEEP_WIDTH = 8
) (
  input  logic [7:0]              base,
  output logic [8*KEEP_WIDTH-1:0] tdata
);

  always_comb begin
    tdata = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      tdata[8*k +: 8] = base + 8'(k);
    end
  end

endmodule

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - command-driven AXI4-Stream frame generator with counted length
module axis_frame_gen
  import axis_frame_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [7:0]            cmd_seed,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  zero_len,
  output logic [31:0]           frame_count
);

  localparam logic [LEN_WIDTH-1:0] STEP = (KEEP_ENABLE != 0) ? LEN_WIDTH'(KEEP_WIDTH)
                                                             : LEN_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [7:0]              offset_q, offset_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic                    zero_len_q, zero_len_d;
  logic                    ready_en_q, ready_en_d;
  logic [31:0]             frame_count_q, frame_count_d;

  logic                    accept, adv, complete, load_cmd, beat_last;
  logic [LEN_WIDTH-1:0]    src_rem, rem_mod;
  logic [7:0]              src_base;
  logic [KEEP_WIDTH-1:0]   keep_beat;
  logic [8*KEEP_WIDTH-1:0] pat, data_beat;

  axis_frame_gen_pattern #(.KEEP_WIDTH(KEEP_WIDTH)) u_pattern (
    .base  (src_base),
    .tdata (pat)
  );

  assign adv       = tvalid_q & m_axis_tready;
  assign complete  = adv & tlast_q;
  // ready_en_q keeps cmd_ready low while reset is held and for the first edge after it.
  assign cmd_ready = ready_en_q & ((state_q == IDLE) | complete);
  assign accept    = cmd_valid & cmd_ready;
  assign load_cmd  = accept & (cmd_len != '0);

  // Next beat is built either from a fresh command or from the running counters.
  always_comb begin
    src_rem   = load_cmd ? cmd_len : rem_q;
    src_base  = load_cmd ? cmd_seed : offset_q;
    beat_last = (src_rem <= STEP);
    rem_mod   = src_rem % LEN_WIDTH'(KEEP_WIDTH);
    if ((KEEP_ENABLE == 0) || !beat_last) keep_beat = '1;
    else keep_beat = KEEP_WIDTH'(keep_mask(32'(rem_mod), KEEP_WIDTH));
    data_beat = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      data_beat[8*k +: 8] = keep_beat[k] ? pat[8*k +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    offset_d      = offset_q;
    tdata_d       = tdata_q;
    tkeep_d       = tkeep_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    zero_len_d    = accept & (cmd_len == '0);
    ready_en_d    = 1'b1;
    frame_count_d = frame_count_q + {31'd0, complete};
    if (load_cmd || (adv && !tlast_q)) begin
      state_d  = SEND;
      tvalid_d = 1'b1;
      tdata_d  = DATA_WIDTH'(data_beat);
      tkeep_d  = keep_beat;
      tlast_d  = beat_last;
      rem_d    = beat_last ? '0 : (src_rem - STEP);
      offset_d = src_base + 8'(KEEP_WIDTH);
    end else if (complete) begin
      state_d  = IDLE;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tdata_d  = '0;
      tkeep_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      offset_q      <= '0;
      tdata_q       <= '0;
      tkeep_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      zero_len_q    <= 1'b0;
      ready_en_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      offset_q      <= offset_d;
      tdata_q       <= tdata_d;
      tkeep_q       <= tkeep_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      zero_len_q    <= zero_len_d;
      ready_en_q    <= ready_en_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = (state_q == SEND);
  assign zero_len      = zero_len_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb/tb_axis_frame_gen.sv - directed and randomized frame checks against a byte-level model
module tb_axis_frame_gen;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic [7:0]    cmd_seed = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          busy;
  logic          zero_len;
  logic [31:0]   frame_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_fc = 0;

  axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_len       (cmd_len),
    .cmd_seed      (cmd_seed),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .zero_len      (zero_len),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: byte at frame offset n is seed+n; lanes past the length are empty.
  function automatic logic [63:0] exp_data(input int len, input logic [7:0] seed, input int b);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < KW; k++) begin
      int lane;
      lane = b * KW + k;
      if (lane < len) d[8*k +: 8] = 8'(int'(seed) + lane);
    end
    return d;
  endfunction

  function automatic logic [7:0] exp_keep(input int len, input int b);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < KW; k++) if (b * KW + k < len) m[k] = 1'b1;
    return m;
  endfunction

  function automatic int n_beats(input int len);
    return (len + KW - 1) / KW;
  endfunction

  task automatic issue_cmd(input int len, input logic [7:0] seed);
    int w;
    @(negedge clk);
    cmd_len   = LW'(len);
    cmd_seed  = seed;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
  endtask

  task automatic check_beat(input int len, input logic [7:0] seed, input int b);
    check("tdata", m_axis_tdata, exp_data(len, seed, b));
    check("tkeep", m_axis_tkeep, exp_keep(len, b));
    check("tlast", m_axis_tlast, (b == n_beats(len) - 1));
  endtask

  task automatic collect(input int len, input logic [7:0] seed, input int stall_pct);
    int nb, b, cyc;
    logic stalled;
    logic [63:0] hd;
    logic [7:0] hk;
    logic hl;
    nb = n_beats(len);
    b = 0;
    cyc = 0;
    stalled = 1'b0;
    while (b < nb && cyc < nb * 20 + 50) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check("tvalid_mid", m_axis_tvalid, 1);
      check("busy_mid", busy, 1);
      if (stalled) begin
        check("hold_tdata", m_axis_tdata, hd);
        check("hold_tkeep", m_axis_tkeep, hk);
        check("hold_tlast", m_axis_tlast, hl);
      end
      m_axis_tready = ($urandom_range(99) >= stall_pct);
      if (m_axis_tready) begin
        check_beat(len, seed, b);
        b++;
        stalled = 1'b0;
      end else begin
        hd = m_axis_tdata;
        hk = m_axis_tkeep;
        hl = m_axis_tlast;
        stalled = 1'b1;
      end
      cyc++;
    end
    check("beats_done", b, nb);
  endtask

  task automatic finish_frame();
    @(negedge clk);
    check("tvalid_after", m_axis_tvalid, 0);
    check("busy_after", busy, 0);
    check("frame_count", frame_count, exp_fc);
  endtask

  task automatic run_frame(input int len, input logic [7:0] seed, input int stall_pct);
    issue_cmd(len, seed);
    if (len == 0) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check("zero_len_pulse", zero_len, 1);
      check("zero_tvalid", m_axis_tvalid, 0);
      @(negedge clk);
      check("zero_len_clear", zero_len, 0);
      check("zero_tvalid2", m_axis_tvalid, 0);
      check("zero_frame_count", frame_count, exp_fc);
    end else begin
      collect(len, seed, stall_pct);
      exp_fc++;
      finish_frame();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_zero_len", zero_len, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_frame_count", frame_count, 0);
    rst_n = 1'b1;

    run_frame(20, 8'h10, 0);
    run_frame(16, 8'h21, 0);
    run_frame(8, 8'hFC, 0);
    run_frame(37, 8'($urandom), 50);

    // Back-to-back: second command accepted on the first frame's tlast cycle.
    m_axis_tready = 1'b1;
    issue_cmd(8, 8'h40);
    @(negedge clk);
    check_beat(8, 8'h40, 0);
    check("b2b_tvalid0", m_axis_tvalid, 1);
    check("b2b_cmd_ready_on_tlast", cmd_ready, 1);
    cmd_len  = LW'(9);
    cmd_seed = 8'h80;
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_fc++;
    check("b2b_count1", frame_count, exp_fc);
    check("b2b_tvalid1", m_axis_tvalid, 1);
    check_beat(9, 8'h80, 0);
    @(negedge clk);
    check("b2b_tvalid2", m_axis_tvalid, 1);
    check_beat(9, 8'h80, 1);
    exp_fc++;
    finish_frame();

    run_frame(0, 8'h77, 0);
    run_frame(65535, 8'h5A, 0);

    repeat (6) run_frame(int'($urandom_range(70, 1)), 8'($urandom), 40);

    // Reset in the middle of a 10-beat frame.
    m_axis_tready = 1'b1;
    issue_cmd(80, 8'h33);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check_beat(80, 8'h33, b);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_tlast", m_axis_tlast, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_frame_count", frame_count, 0);
    exp_fc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(20, 8'($urandom), 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_frame_gen.md
Name: axis_frame_gen

Overview:
Transmit-side companion to the AXI4-Stream frame length monitor. It accepts a command holding a frame length and a data seed, then drives one AXI4-Stream frame of exactly that length. Bytes follow a deterministic incrementing pattern, and tkeep is low-aligned on the final beat. The monitor measures such a frame back to the commanded length, so the pair forms a loopback self-test for stream paths and MAC/FIFO bring-up.

Parameters:
- DATA_WIDTH, 64: tdata width in bits; must be 8*KEEP_WIDTH when KEEP_ENABLE=1.
- KEEP_ENABLE, (DATA_WIDTH>8): drive a meaningful tkeep. When 0, tkeep is all ones and length counts beats.
- KEEP_WIDTH, (DATA_WIDTH/8): byte lanes per beat.
- LEN_WIDTH, 16: width of the length field and of the internal remaining-count register.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_len  in  LEN_WIDTH  frame length: bytes when KEEP_ENABLE=1, beats otherwise.
- cmd_seed  in  8  value of byte 0 of the frame.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last beat of the frame.
- busy  out  1  frame in progress (state is SEND).
- zero_len  out  1  one-cycle pulse when a zero-length command is accepted.
- frame_count  out  32  number of frames completed; wraps modulo 2^32.

Behaviour:
- Reset (async assert, sync deassert expected from upstream):
  - tvalid, tlast, busy, zero_len and cmd_ready are 0.
  - tdata, tkeep and frame_count are 0.
  - State is IDLE.
  - Reset asserted mid-frame abandons the frame immediately: no tlast is issued and frame_count is not incremented.
- States:
  - IDLE: cmd_ready=1.
  - SEND: cmd_ready = tvalid & tready & tlast. A new command can be accepted in the same cycle the last beat completes, giving back-to-back frames with no bubble.
- Command acceptance (cmd_valid & cmd_ready at edge N):
  - cmd_len=0: no beats; zero_len=1 for cycle N+1; state becomes or stays IDLE.
  - cmd_len>0: tvalid=1 from cycle N+1; state becomes SEND.
- Beat count = ceil(cmd_len/KEEP_WIDTH) when KEEP_ENABLE=1, else cmd_len.
- Byte pattern: lane k of beat b = (cmd_seed + b*KEEP_WIDTH + k) mod 256. Lanes with tkeep=0 are driven 0.
- tkeep:
  - All ones on every beat except the last.
  - Last beat: low r bits set, where r = cmd_len mod KEEP_WIDTH. If r=0, all ones.
- tlast=1 only on the final beat.
- Handshake:
  - Outputs are registered.
  - While tvalid=1 and tready=0, tdata, tkeep and tlast hold stable.
  - tvalid never drops mid-frame except on reset.
  - A beat advances only on tvalid & tready.
- Last-beat completion:
  - frame_count increments in the completion cycle.
  - With no new command: tvalid=0 next cycle and state returns to IDLE.
  - With a new command accepted in the same cycle: the first beat of the next frame is presented next cycle.
- Arithmetic:
  - The remaining-lane counter is LEN_WIDTH bits wide and counts down by KEEP_WIDTH (or by 1 when KEEP_ENABLE=0).
  - Maximum length 2^LEN_WIDTH-1 needs no extra width.
  - The byte offset is 8 bits and wraps naturally.

Decomposition:
- Shared package axis_frame_pkg: state encoding (IDLE, SEND) and a function keep_mask(r, KEEP_WIDTH) returning the low-aligned tkeep for remainder r. The monitor can reuse keep_mask for its lane count.
- One sub-module is natural: axis_frame_gen_pattern, a combinational lane-pattern generator (base offset in, tdata out). Everything else stays flat.

Test Plan (DATA_WIDTH=64, loopback through the frame length monitor):
- cmd_len=20, seed=0x10, tready=1: 3 beats. tkeep FF, FF, 0F; tlast on beat 3; beat 0 bytes 10..17, beat 2 bytes 20..23. Monitor reports 20; frame_count=1.
- cmd_len=16: exactly 2 beats, last tkeep=FF. Then seed=0xFC, len=8: bytes FC,FD,FE,FF,00,01,02,03 (byte wrap).
- Random tready with ~50% stalls, len=37: tdata/tkeep/tlast stable during each stall; 5 beats total, last tkeep=1F; monitor reports 37.
- Back-to-back commands len=8 then len=9, tready=1: beats on consecutive cycles with no bubble; cmd_ready=1 on the first frame's tlast cycle; frame_count goes 1 then 2.
- cmd_len=0: no tvalid; zero_len pulses exactly one cycle; frame_count unchanged. cmd_len=65535: 8192 beats, last tkeep=7F.
- rst_n asserted on beat 2 of a 10-beat frame: tvalid=0 immediately, frame_count=0. A new command after release produces a correct frame.
